// File: rtl/mem_loader_pkg.sv
// Shared states and constants for the on-chip memory stream loader.
// MEM_LOADER_READBACK_EN adds the VERIFY and CHECK states.
package mem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DEPTH      = 10024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
`ifdef MEM_LOADER_READBACK_EN
    ST_VERIFY  = 3'd4,
    ST_CHECK   = 3'd5,
`endif
    ST_FINISH  = 3'd3
  } loader_state_e;

  // Expands per-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Little-endian byte-to-word packer: lane index, byte placement, enable
// accumulation and detection of a word that is ready to be written.
module mem_loader_packer
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  input  logic        last,
  output logic [31:0] word_nxt,
  output logic [3:0]  be_nxt,
  output logic        flush
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_r;
  logic [31:0] word_r;
  logic [3:0]  be_r;

  // Word and enables as they will look once the current byte is merged.
  always_comb begin
    word_nxt = word_r;
    be_nxt   = be_r;
    if (accept) begin
      word_nxt[{idx_r, 3'b000} +: 8] = byte_data;
      be_nxt[idx_r]                  = 1'b1;
    end else begin
      word_nxt = word_r;
      be_nxt   = be_r;
    end
  end

  assign flush = accept && ((idx_r == LAST_LANE) || last);

  // Accumulation registers; emptied whenever the loader is not collecting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= 2'd0;
      word_r <= 32'h0;
      be_r   <= 4'h0;
    end else if (clear) begin
      idx_r  <= 2'd0;
      word_r <= 32'h0;
      be_r   <= 4'h0;
    end else if (accept) begin
      idx_r  <= idx_r + 2'd1;
      word_r <= word_nxt;
      be_r   <= be_nxt;
    end
  end

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Streams bytes into 32-bit on-chip RAM words with byte enables.
// Define MEM_LOADER_READBACK_EN to read back and verify every written word.
module onchip_mem_stream_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              wrapped,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
`ifdef MEM_LOADER_READBACK_EN
  input  logic [31:0]       mem_readdata,
  output logic              verify_err,
`endif
  output logic              mem_clken
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] MAX_COUNT = {ADDR_W{1'b1}};

  loader_state_e     state_r;
  logic              in_ready_r, busy_r, done_r, last_r;
  logic              cs_r, wr_r, wrapped_r;
  logic [3:0]        be_r;
  logic [31:0]       wdata_r;
  logic [ADDR_W-1:0] addr_r, count_r;
  logic              start_s, accept_s, word_end_s, pk_clear_s, flush_s;
  logic [31:0]       word_nxt_s;
  logic [3:0]        be_nxt_s;

  assign start_s    = start && (state_r == ST_IDLE);
  assign accept_s   = in_valid && in_ready_r;
  assign pk_clear_s = (state_r != ST_COLLECT);
`ifdef MEM_LOADER_READBACK_EN
  assign word_end_s = (state_r == ST_CHECK);
`else
  assign word_end_s = (state_r == ST_WRITE);
`endif

  mem_loader_packer u_packer (
    .clk       (clk),
    .rst_n     (reset_n),
    .clear     (pk_clear_s),
    .accept    (accept_s),
    .byte_data (in_data),
    .last      (in_last),
    .word_nxt  (word_nxt_s),
    .be_nxt    (be_nxt_s),
    .flush     (flush_s)
  );

  // Main sequencer; memory-port strobes are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      last_r     <= 1'b0;
      cs_r       <= 1'b0;
      wr_r       <= 1'b0;
      be_r       <= 4'h0;
      wdata_r    <= 32'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r    <= ST_COLLECT;
            busy_r     <= 1'b1;
            in_ready_r <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (flush_s) begin
            state_r    <= ST_WRITE;
            in_ready_r <= 1'b0;
            cs_r       <= 1'b1;
            wr_r       <= 1'b1;
            be_r       <= be_nxt_s;
            wdata_r    <= word_nxt_s;
            last_r     <= in_last;
          end
        end
`ifdef MEM_LOADER_READBACK_EN
        ST_WRITE: begin
          wr_r    <= 1'b0;
          state_r <= ST_VERIFY;
        end
        ST_VERIFY: begin
          cs_r    <= 1'b0;
          state_r <= ST_CHECK;
        end
        ST_CHECK: begin
          be_r <= 4'h0;
          if (last_r) begin
            state_r <= ST_FINISH;
            done_r  <= 1'b1;
          end else begin
            state_r    <= ST_COLLECT;
            in_ready_r <= 1'b1;
          end
        end
`else
        ST_WRITE: begin
          cs_r <= 1'b0;
          wr_r <= 1'b0;
          be_r <= 4'h0;
          if (last_r) begin
            state_r <= ST_FINISH;
            done_r  <= 1'b1;
          end else begin
            state_r    <= ST_COLLECT;
            in_ready_r <= 1'b1;
          end
        end
`endif
        ST_FINISH: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          cs_r       <= 1'b0;
          wr_r       <= 1'b0;
        end
      endcase
    end
  end

  // Word address, saturating word counter and sticky wrap flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r    <= ZERO_ADDR;
      count_r   <= ZERO_ADDR;
      wrapped_r <= 1'b0;
    end else if (start_s) begin
      addr_r    <= (start_addr > LAST_ADDR) ? ZERO_ADDR : start_addr;
      count_r   <= ZERO_ADDR;
      wrapped_r <= 1'b0;
    end else if (word_end_s) begin
      if (count_r != MAX_COUNT) begin
        count_r <= count_r + ADDR_W'(1);
      end
      if (addr_r == LAST_ADDR) begin
        addr_r    <= ZERO_ADDR;
        wrapped_r <= 1'b1;
      end else begin
        addr_r <= addr_r + ADDR_W'(1);
      end
    end
  end

`ifdef MEM_LOADER_READBACK_EN
  logic verify_err_r;

  // Readback data arrives in CHECK; only written lanes are compared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      verify_err_r <= 1'b0;
    end else if (start_s) begin
      verify_err_r <= 1'b0;
    end else if ((state_r == ST_CHECK) &&
                 (((mem_readdata ^ wdata_r) & lane_mask(be_r)) != 32'h0)) begin
      verify_err_r <= 1'b1;
    end
  end

  assign verify_err = verify_err_r;
`endif

  assign in_ready       = in_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign word_count     = count_r;
  assign wrapped        = wrapped_r;
  assign mem_address    = addr_r;
  assign mem_byteenable = be_r;
  assign mem_chipselect = cs_r;
  assign mem_write      = wr_r;
  assign mem_writedata  = wdata_r;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Directed self-checking bench for onchip_mem_stream_loader; also covers
// the readback checks when built with MEM_LOADER_READBACK_EN.
module tb_onchip_mem_stream_loader;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 10024;
`ifdef MEM_LOADER_READBACK_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n, start, in_valid, in_last;
  logic [ADDR_W-1:0] start_addr;
  logic [7:0]        in_data;
  logic              in_ready, busy, done, wrapped;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [ADDR_W-1:0] word_count, mem_address;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int t1, t2;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  logic [3:0]        wq_be[$];
  logic [7:0]        seq8 [8];

`ifdef MEM_LOADER_READBACK_EN
  logic [31:0]       mem_readdata = 32'h0;
  logic              verify_err;
  logic [31:0]       mem_model [256];
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_a = 14'h0;

  // Memory with 1-cycle read latency; optionally flips bit 0 on one address.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      mem_model[mem_address[7:0]] <= mem_writedata;
    else if (mem_chipselect)
      mem_readdata <= mem_model[mem_address[7:0]] ^
                      ((corrupt_en && mem_address == corrupt_a) ? 32'h1 : 32'h0);
  end
`endif

  onchip_mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .start_addr     (start_addr),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .busy           (busy),
    .done           (done),
    .word_count     (word_count),
    .wrapped        (wrapped),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
`ifdef MEM_LOADER_READBACK_EN
    .mem_readdata   (mem_readdata),
    .verify_err     (verify_err),
`endif
    .mem_clken      (mem_clken)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and done-pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_chipselect === 1'b1 && mem_write === 1'b1) begin
      wq_addr.push_back(mem_address);
      wq_data.push_back(mem_writedata);
      wq_be.push_back(mem_byteenable);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    start = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
    check("start state", {busy, in_ready, wrapped, word_count}, {1'b1, 1'b1, 1'b0, 14'd0});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    t = 0;
    in_data = b;
    in_valid = 1'b1;
    in_last = l;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready timeout", 64'(t), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic write_check(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    check(tag, {mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata},
               {1'b1, 1'b1, a, be, d});
  endtask

  task automatic finish_check(input string tag);
    repeat (EXTRA) @(negedge clk);
    @(negedge clk);
    check({tag, " done"}, {done, busy}, 2'b11);
    @(negedge clk);
    check({tag, " idle"}, {done, busy, in_ready}, 3'b000);
    exp_done++;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_addr = 14'h0;
    in_data = 8'h0; in_valid = 1'b0; in_last = 1'b0;
    seq8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (2) @(negedge clk);
    check("reset ctrl", {in_ready, busy, done, wrapped, mem_chipselect, mem_write, mem_byteenable}, 10'h0);
    check("reset data", {word_count, mem_address, mem_writedata}, 60'h0);
    check("reset clken", mem_clken, 1'b1);
`ifdef MEM_LOADER_READBACK_EN
    check("reset verify_err", verify_err, 1'b0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // Two full words, continuous stream.
    do_start(14'h0010);
    for (int i = 0; i < 4; i++) send_byte(seq8[i], 1'b0);
    write_check("t1 w0", 14'h0010, 32'h44332211, 4'hF);
    t1 = cyc;
    for (int i = 4; i < 8; i++) send_byte(seq8[i], i == 7);
    write_check("t1 w1", 14'h0011, 32'h88776655, 4'hF);
    t2 = cyc;
    check("t1 throughput", 64'(t2 - t1), 64'(5 + EXTRA));
    finish_check("t1");
    check("t1 count", {word_count, wrapped}, {14'd2, 1'b0});
    check("t1 done pulses", 64'(done_cnt), 64'd1);

    // Partial final word.
    do_start(14'h0020);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    write_check("t2 partial", 14'h0020, 32'h00CCBBAA, 4'b0111);
    finish_check("t2");
    check("t2 count", word_count, 14'd1);

    // Address wrap from DEPTH-1.
    do_start(14'd10023);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0);
    write_check("t3 w0", 14'd10023, 32'h04030201, 4'hF);
    for (int i = 4; i < 8; i++) send_byte(8'(i + 1), i == 7);
    write_check("t3 w1", 14'd0, 32'h08070605, 4'hF);
    finish_check("t3");
    check("t3 wrap", {word_count, wrapped}, {14'd2, 1'b1});

    // Out-of-range start address maps to 0.
    do_start(14'd10024);
    send_byte(8'h5A, 1'b1);
    write_check("t3b oob addr", 14'd0, 32'h0000005A, 4'b0001);
    finish_check("t3b");
    check("t3b flags", {word_count, wrapped}, {14'd1, 1'b0});

    // Gapped stream, with an ignored start mid-load.
    wq_addr.delete(); wq_data.delete(); wq_be.delete();
    do_start(14'h0030);
    for (int i = 0; i < 8; i++) begin
      send_byte(seq8[i], i == 7);
      if (i == 7) break;
      if (i == 1) begin
        start = 1'b1;
        start_addr = 14'h0099;
      end
      @(negedge clk);
      start = 1'b0;
    end
    finish_check("t4");
    check("t4 n_writes", 64'(wq_addr.size()), 64'd2);
    if (wq_addr.size() == 2) begin
      check("t4 w0", {wq_addr[0], wq_be[0], wq_data[0]}, {14'h0030, 4'hF, 32'h44332211});
      check("t4 w1", {wq_addr[1], wq_be[1], wq_data[1]}, {14'h0031, 4'hF, 32'h88776655});
    end

    // Reset mid-word discards the partial word.
    wq_addr.delete(); wq_data.delete(); wq_be.delete();
    do_start(14'h0040);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5 in reset", {busy, in_ready, mem_write, word_count}, 17'h0);
    reset_n = 1'b1;
    @(negedge clk);
    do_start(14'h0041);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    write_check("t5 word", 14'h0041, 32'hEFBEADDE, 4'hF);
    finish_check("t5");
    check("t5 n_writes", 64'(wq_addr.size()), 64'd1);

`ifdef MEM_LOADER_READBACK_EN
    check("rb clean", verify_err, 1'b0);
    corrupt_en = 1'b1;
    corrupt_a = 14'h0051;
    do_start(14'h0050);
    for (int i = 0; i < 8; i++) send_byte(seq8[i], i == 7);
    finish_check("rb corrupt");
    check("rb corrupt err", verify_err, 1'b1);
    corrupt_en = 1'b0;
    do_start(14'h0060);
    check("rb cleared", verify_err, 1'b0);
    send_byte(8'h77, 1'b1);
    finish_check("rb tail");
    check("rb tail err", verify_err, 1'b0);
`endif

    @(negedge clk);
    check("done pulses total", 64'(done_cnt), 64'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/onchip_mem_stream_loader.md
# onchip_mem_stream_loader

Upstream feeder for the 32-bit single-port on-chip memory. Accepts a byte stream with a valid/ready handshake, packs bytes little-endian into 32-bit words, and issues single-cycle word writes with byte enables on the memory's slave port, starting at a programmable word address. Used to load data or images into on-chip RAM at run time without going through the processor.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the memory port
- DEPTH, 10024, number of 32-bit words in the target memory; the address wraps at DEPTH-1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load; ignored while busy=1
- start_addr  in  ADDR_W  first word address, sampled on start; values >= DEPTH are treated as 0
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_last  in  1  qualifies the final byte of the load
- in_ready  out  1  loader accepts a byte this cycle
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the load completes
- word_count  out  ADDR_W  words written in the current or last load; saturates at all-ones
- wrapped  out  1  sticky flag: the address wrapped during this load; cleared on start
- mem_address  out  ADDR_W  memory word address
- mem_byteenable  out  4  byte lanes written
- mem_chipselect  out  1  memory select
- mem_write  out  1  write strobe
- mem_writedata  out  32  packed word
- mem_clken  out  1  memory clock enable; constant 1

## Operation
- States: IDLE, COLLECT, WRITE, FINISH. Under the macro, VERIFY and CHECK are also present.
- IDLE: on start, go to COLLECT. Load the address register from start_addr, clear the lane index, word_count and wrapped, and set busy.
- COLLECT: in_ready=1. A byte is accepted when in_valid and in_ready are both 1. It goes to lane idx: byte 0 → bits 7:0, byte 3 → bits 31:24, and the lane's enable bit is set.
  - After the 4th byte, or any accepted byte with in_last=1, go to WRITE.
- WRITE, one cycle: mem_chipselect=mem_write=1, with the packed word and the accumulated enables.
  - A partial last word writes only its filled lanes (e.g. 2 bytes → byteenable 4'b0011).
  - On exit: increment word_count. Advance the address; DEPTH-1 → 0 sets wrapped.
  - Clear the enables and the lane index.
  - Next state is COLLECT, or FINISH if the last byte was in this word.
- FINISH: pulse done, clear busy, go to IDLE.
- in_last with 0 bytes cannot occur, because in_last always rides on an accepted byte.
- start during busy is ignored. in_valid while not in COLLECT is held off by in_ready=0.
- Asserting reset_n low at any point returns the block to IDLE and discards any partial word. A write already presented completes only if its cycle was already clocked.

## Timing
- Reset values: in_ready, busy, done, wrapped, mem_chipselect, mem_write, mem_byteenable = 0; word_count, mem_address, mem_writedata = 0; mem_clken = 1.
- Memory outputs are registered. The write is visible on the port in the cycle immediately after the 4th byte handshake.
- Throughput: 4 bytes per 5 cycles with continuous in_valid.
- done asserts exactly 1 cycle after the final WRITE cycle.
- busy rises 1 cycle after start.

## Configuration
- MEM_LOADER_READBACK_EN defined:
  - Adds input mem_readdata[31:0] and output verify_err (sticky, cleared on start).
  - WRITE is followed by VERIFY, a read at the same address with mem_chipselect=1 and mem_write=0.
  - VERIFY is followed by CHECK. In CHECK, mem_readdata (1-cycle read latency) is compared to the written word under byteenable. A mismatch sets verify_err.
  - The address advances after CHECK. Throughput is 4 bytes per 7 cycles.
- Undefined: those ports, states and cycles are absent.

## Structure
- Package mem_loader_pkg holds:
  - the state enum
  - BYTES_PER_WORD = 4
  - the default ADDR_W and DEPTH values
- Sub-module mem_loader_packer holds the lane index, byte shift-in, enable accumulation and full/last detection. The top level holds the FSM and the address, count and flag logic.

## Test plan
- start_addr=0x0010, bytes 11 22 33 44 55 66 77 88 (last on 88) → writes 0x44332211 @0x0010 and 0x88776655 @0x0011, both be=4'hF; word_count=2; done pulses once.
- start_addr=0x0020, bytes AA BB CC with last → single write 0x00CCBBAA @0x0020, be=4'b0111.
- start_addr=DEPTH-1, 8 bytes → writes at 10023 then 0; wrapped=1.
- in_valid toggled every other cycle → the packed words are identical to the continuous case, and no byte is dropped or duplicated.
- reset_n pulsed low after 2 bytes, then a new start with 4 bytes → no write from the partial word; the new word is written correctly.
- With MEM_LOADER_READBACK_EN: the memory model corrupts bit 0 on readback of word 1 → verify_err=1; on a clean run verify_err=0.
